wshb_rr_arbiter: RTL and testbench
==================================

WSHB_RR_ARBITER -- requirements
Module: wshb_rr_arbiter

Interface
REQ-001 Parameter NM, default 3: number of Wishbone masters sharing one SDRAM slave port.
REQ-002 Parameter QUANTUM, default 64: max acks per grant while another master waits; 0 = unlimited.
REQ-003 Parameter AW, default 32: address width.
REQ-004 Port sys_clk  in  1: system clock (100 MHz); all logic on rising edge.
REQ-005 Port sys_rst_n  in  1: asynchronous active-low reset.
REQ-006 Port m_cyc  in  NM: per-master cyc.
REQ-007 Port m_stb  in  NM: per-master stb.
REQ-008 Port m_we  in  NM: per-master write enable.
REQ-009 Port m_adr  in  NM*AW: per-master address, master i at bits [i*AW +: AW].
REQ-010 Port m_dat_ms  in  NM*32: per-master write data.
REQ-011 Port m_sel  in  NM*4: per-master byte selects.
REQ-012 Port m_urgent  in  1: master 0 (VGA reader) FIFO below threshold.
REQ-013 Port m_ack  out  NM: per-master ack.
REQ-014 Port m_dat_sm  out  32: read data broadcast to all masters.
REQ-015 Port s_cyc, s_stb, s_we  out  1 each: slave-side controls.
REQ-016 Port s_adr  out  AW; s_dat_ms  out  32; s_sel  out  4: slave-side address/data/select.
REQ-017 Port s_ack  in  1; s_dat_sm  in  32: slave response.
REQ-018 Port gnt  out  NM: registered one-hot grant, for debug/status.

Function
REQ-019 FSM states: IDLE, GRANT, HANDOVER.
REQ-020 IDLE: if any m_cyc high, next cycle GRANT with gnt one-hot of chosen master; else stay IDLE.
REQ-021 Choice: if m_urgent and m_cyc[0], master 0; otherwise round-robin, first requester scanning upward from (last+1) mod NM.
REQ-022 last updates to the chosen index on each IDLE->GRANT transition.
REQ-023 Slave mux: s_cyc=m_cyc[g], s_stb=m_stb[g], s_we/s_adr/s_dat_ms/s_sel from master g, only in GRANT; all slave outputs 0 otherwise.
REQ-024 m_ack[i]=s_ack AND state==GRANT AND gnt[i]; non-granted masters see m_ack=0 (wait states).
REQ-025 m_dat_sm=s_dat_sm, unregistered.
REQ-026 Grant latency: request in IDLE at edge t -> s_cyc asserted from edge t+1.
REQ-027 ack_cnt counts s_ack in GRANT; cleared on entry to GRANT; width $clog2(QUANTUM+1).
REQ-028 GRANT, m_cyc[g] low -> IDLE next cycle, gnt cleared.
REQ-029 GRANT, QUANTUM!=0, s_ack with ack_cnt==QUANTUM-1, another m_cyc high -> HANDOVER next cycle; the acked transfer completes normally.
REQ-030 Quota reached with no other requester: ack_cnt saturates at QUANTUM, grant retained; preemption on the first ack after a competitor appears.
REQ-031 HANDOVER: all slave outputs 0 for exactly one cycle, gnt cleared, then IDLE.
REQ-032 Urgent override acts only at arbitration points (IDLE); never aborts an unacked transfer.
REQ-033 Preempted master keeps cyc/stb asserted and re-competes; no transfer is lost or duplicated.
REQ-034 s_ack outside GRANT is ignored.

Reset
REQ-035 sys_rst_n low asynchronously forces IDLE, gnt=0, ack_cnt=0, last=NM-1 (master 0 first); all slave outputs and m_ack 0 while reset.
REQ-036 Reset mid-transfer abandons the transfer; no ack is forwarded after reset assertion.

Verification
REQ-037 Single requester: m_cyc=3'b010, slave acks every cycle, 10 transfers -> gnt=3'b010 from cycle 1, 10 m_ack[1] pulses, s_adr tracks m_adr[1].
REQ-038 Round-robin: all three request at once after reset, each drops cyc after 1 ack -> grant order 0,1,2,0.
REQ-039 Quantum: QUANTUM=4, masters 1 and 2 stream continuously -> 4 acks to m1, one HANDOVER cycle with s_cyc=0, IDLE, then 4 acks to m2.
REQ-040 Urgent: master 1 granted, masters 0 and 2 waiting, m_urgent=1 at preemption -> master 0 granted next, not master 2.
REQ-041 No competitor: QUANTUM=4, only master 2 requests, 20 acks -> no HANDOVER, gnt stays 3'b100.
REQ-042 Reset mid-burst: sys_rst_n low after 3 acks to master 0 -> gnt=0, s_cyc=0 immediately; after release, master 0 granted first again.

Source files
------------

// File: rtl/wshb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wshb_rr_arbiter
//   Shares one Wishbone SDRAM slave port between NM masters. Masters are
//   served round-robin, master 0 (the VGA reader) can jump the queue when its
//   FIFO is running low, and a master holding the port while others wait is
//   preempted after QUANTUM acknowledged transfers.
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   m_cyc/m_stb/m_we     per-master Wishbone controls (NM bits each)
//   m_adr                per-master address, master i at [i*AW +: AW]
//   m_dat_ms, m_sel      per-master write data (32b) and byte selects (4b)
//   m_urgent             master 0 FIFO below threshold
//   m_ack                per-master ack (only the granted master sees it)
//   m_dat_sm             slave read data broadcast to every master
//   s_cyc..s_sel         muxed request towards the slave
//   s_ack, s_dat_sm      slave response
//   gnt                  registered one-hot grant (status/debug)
// ---------------------------------------------------------------------------
module wshb_rr_arbiter #(
    parameter int NM      = 3,
    parameter int QUANTUM = 64,
    parameter int AW      = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [NM-1:0]    m_cyc,
    input  logic [NM-1:0]    m_stb,
    input  logic [NM-1:0]    m_we,
    input  logic [NM*AW-1:0] m_adr,
    input  logic [NM*32-1:0] m_dat_ms,
    input  logic [NM*4-1:0]  m_sel,
    input  logic             m_urgent,
    output logic [NM-1:0]    m_ack,
    output logic [31:0]      m_dat_sm,
    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [AW-1:0]    s_adr,
    output logic [31:0]      s_dat_ms,
    output logic [3:0]       s_sel,
    input  logic             s_ack,
    input  logic [31:0]      s_dat_sm,
    output logic [NM-1:0]    gnt
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
    localparam logic [CW-1:0] QMAX  = CW'(QUANTUM);
    localparam logic [CW-1:0] QLAST = (QUANTUM > 0) ? CW'(QUANTUM - 1) : '0;

    typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} state_t;

    state_t        state, state_nx;
    logic [NM-1:0] gnt_nx;
    logic [CW-1:0] ack_cnt, ack_cnt_nx;
    logic [IW-1:0] last, last_nx;
    logic [IW-1:0] pick;
    logic [IW-1:0] cur;
    logic          found;
    logic          others;
    int            idx;

    // Index of the currently granted master (gnt is one-hot or zero).
    always_comb begin
        cur = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt[i]) cur = IW'(i);
        end
    end

    // Arbitration choice: urgent master 0 first, else first requester scanning
    // upward from the one after the last winner.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NM; k++) begin
            idx = (int'(last) + k) % NM;
            if (!found && m_cyc[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        if (m_urgent && m_cyc[0]) pick = '0;
    end

    // Any master other than the granted one waiting for the port.
    assign others = |(m_cyc & ~gnt);

    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        ack_cnt_nx = ack_cnt;
        last_nx    = last;
        unique case (state)
            IDLE: begin
                if (|m_cyc) begin
                    state_nx   = GRANT;
                    gnt_nx     = NM'(1) << pick;
                    last_nx    = pick;
                    ack_cnt_nx = '0;
                end
            end
            GRANT: begin
                if (!m_cyc[cur]) begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                end else if (s_ack) begin
                    // The ack that exhausts the quota is still forwarded; the
                    // port is released on the following cycle. Once the count
                    // has saturated, the first ack seen with a competitor waiting
                    // triggers the handover.
                    if (QUANTUM != 0 && ack_cnt >= QLAST && others) begin
                        state_nx = HANDOVER;
                        gnt_nx   = '0;
                    end
                    if (QUANTUM != 0 && ack_cnt != QMAX)
                        ack_cnt_nx = ack_cnt + CW'(1);
                end
            end
            HANDOVER: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            ack_cnt <= '0;
            last    <= IW'(NM - 1);
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            ack_cnt <= ack_cnt_nx;
            last    <= last_nx;
        end
    end

    // Slave-side mux: driven only while a grant is active, so the slave sees
    // an idle bus in IDLE, HANDOVER and during reset.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        if (state == GRANT) begin
            s_cyc    = m_cyc[cur];
            s_stb    = m_stb[cur];
            s_we     = m_we[cur];
            s_adr    = m_adr[int'(cur)*AW +: AW];
            s_dat_ms = m_dat_ms[int'(cur)*32 +: 32];
            s_sel    = m_sel[int'(cur)*4 +: 4];
        end
    end

    assign m_ack    = (state == GRANT && s_ack) ? gnt : '0;
    assign m_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
module tb_wshb_rr_arbiter;

    localparam int NM = 3;
    localparam int Q  = 4;
    localparam int AW = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [NM*AW-1:0] m_adr;
    logic [NM*32-1:0] m_dat_ms;
    logic [NM*4-1:0]  m_sel;
    logic             m_urgent;
    logic [NM-1:0]    m_ack;
    logic [31:0]      m_dat_sm;
    logic             s_cyc, s_stb, s_we;
    logic [AW-1:0]    s_adr;
    logic [31:0]      s_dat_ms;
    logic [3:0]       s_sel;
    logic             s_ack;
    logic [31:0]      s_dat_sm;
    logic [NM-1:0]    gnt;

    always #5 clk = ~clk;

    wshb_rr_arbiter #(.NM(NM), .QUANTUM(Q), .AW(AW)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_urgent(m_urgent),
        .m_ack(m_ack), .m_dat_sm(m_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel),
        .s_ack(s_ack), .s_dat_sm(s_dat_sm), .gnt(gnt)
    );

    int total = 0;
    int passed = 0;

    // Masters: each holds a count of outstanding transfers and a running address.
    int          pend[NM];
    int          issued[NM];
    int          seen[NM];
    logic [31:0] adr[NM];

    // Reference: who owns the port (-1 nobody), whether the one-cycle gap after
    // a quota preemption is running, acks served in the current tenure.
    int owner = -1;
    bit gap = 1'b0;
    int served = 0;
    int lst = NM - 1;
    int n_ho = 0;
    int order[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input logic [NM-1:0] c, input logic urg);
        if (urg && c[0]) return 0;
        for (int k = 1; k <= NM; k++)
            if (c[(lst + k) % NM]) return (lst + k) % NM;
        return -1;
    endfunction

    task automatic ref_reset();
        owner = -1; gap = 1'b0; served = 0; lst = NM - 1;
    endtask

    task automatic ref_clock(input logic [NM-1:0] c, input logic urg, input logic ack);
        int p;
        if (gap) begin
            gap = 1'b0;
        end else if (owner < 0) begin
            p = rr_pick(c, urg);
            if (p >= 0) begin
                owner = p; lst = p; served = 0; order.push_back(p);
            end
        end else if (!c[owner]) begin
            owner = -1;
        end else if (ack) begin
            if (served + 1 >= Q && (c & ~(NM'(1) << owner)) != 0) begin
                owner = -1; gap = 1'b1; n_ho++;
            end
            if (served < Q) served++;
        end
    endtask

    task automatic add(input int i, input int n);
        pend[i] += n;
        issued[i] += n;
    endtask

    task automatic drive();
        for (int i = 0; i < NM; i++) begin
            m_cyc[i] = (pend[i] > 0);
            m_stb[i] = (pend[i] > 0);
            m_we[i]  = adr[i][2];
            m_adr[i*AW +: AW]    = adr[i];
            m_dat_ms[i*32 +: 32] = ~adr[i];
            m_sel[i*4 +: 4]      = adr[i][5:2];
        end
    endtask

    // One clock cycle: drive, check mid-cycle, advance reference at the edge.
    task automatic step(input bit want_ack);
        logic [NM-1:0] eg, ea, cyc_s;
        logic          es, ewe;
        logic [31:0]   eadr;
        drive();
        s_dat_sm = $urandom;
        eg = '0; es = 1'b0; ewe = 1'b0; eadr = '0;
        if (owner >= 0) begin
            eg = NM'(1) << owner; es = m_cyc[owner]; ewe = m_we[owner]; eadr = adr[owner];
        end
        s_ack = want_ack && (owner < 0 || es);
        ea = s_ack ? eg : '0;
        @(negedge clk);
        chk("gnt", gnt, eg);
        chk("m_ack", m_ack, ea);
        chk("s_cyc", s_cyc, es);
        chk("s_stb", s_stb, es);
        chk("s_we", s_we, ewe);
        chk("s_adr", s_adr, eadr);
        chk("m_dat_sm", m_dat_sm, s_dat_sm);
        for (int i = 0; i < NM; i++) seen[i] += int'(m_ack[i]);
        cyc_s = m_cyc;
        @(posedge clk);
        ref_clock(cyc_s, m_urgent, s_ack);
        for (int i = 0; i < NM; i++)
            if (ea[i] && pend[i] > 0) begin
                pend[i]--;
                adr[i] += 32'd4;
            end
        #1;
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((pend[0] + pend[1] + pend[2] > 0 || owner >= 0 || gap) && n < max) begin
            step(1'b1);
            n++;
        end
        chk({tag, "_within_bound"}, n < max, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ref_reset();
        s_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_s_cyc", s_cyc, 0);
            chk("rst_m_ack", m_ack, 0);
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int ho0, s0, n;
        int exp3[4] = '{1, 2, 1, 2};
        rst_n = 1'b0; m_urgent = 1'b0; s_ack = 1'b0; s_dat_sm = '0;
        for (int i = 0; i < NM; i++) begin
            pend[i] = 0; issued[i] = 0; seen[i] = 0; adr[i] = 32'h1000 * (i + 1);
        end
        drive();
        @(posedge clk); #1;
        do_reset();

        // Single requester, 10 transfers.
        add(1, 10);
        drain("single", 40);
        chk("single_grant", (order.size() == 1) ? order[0] : -1, 1);
        chk("single_acks", seen[1], 10);

        // Round-robin from reset: 0,1,2 then 0 again.
        do_reset();
        order.delete();
        add(0, 1); add(1, 1); add(2, 1);
        drain("rr", 40);
        add(0, 1);
        drain("rr2", 20);
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk("rr_order", order[i], (i == 3) ? 0 : i);

        // Quantum preemption between two streaming masters.
        order.delete();
        ho0 = n_ho;
        s0 = seen[1] + seen[2];
        add(1, 8); add(2, 8);
        drain("quantum", 80);
        chk("quantum_handovers", n_ho - ho0, 3);
        chk("quantum_acks", seen[1] + seen[2] - s0, 16);
        chk("quantum_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk("quantum_order", order[i], exp3[i]);

        // Urgent master 0 wins the arbitration after master 1 is preempted.
        order.delete();
        add(1, 6);
        step(1'b1);
        add(0, 2); add(2, 2);
        m_urgent = 1'b1;
        drain("urgent", 60);
        m_urgent = 1'b0;
        chk("urgent_next", (order.size() > 1) ? order[1] : -1, 0);

        // Quota reached without a competitor: grant kept throughout.
        ho0 = n_ho;
        s0 = seen[2];
        add(2, 20);
        drain("nocomp", 60);
        chk("nocomp_handovers", n_ho - ho0, 0);
        chk("nocomp_acks", seen[2] - s0, 20);

        // Reset in the middle of a burst from master 0.
        add(0, 10);
        n = 0;
        while (pend[0] > 7 && n < 20) begin
            step(1'b1);
            n++;
        end
        chk("midrst_acks_within_bound", n < 20, 1);
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_s_cyc", s_cyc, 0);
        chk("midrst_m_ack", m_ack, 0);
        do_reset();
        order.delete();
        drain("midrst", 40);
        chk("midrst_first", (order.size() > 0) ? order[0] : -1, 0);

        // Random traffic, urgency and slave wait states.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NM; i++)
                if (pend[i] == 0 && $urandom_range(7) == 0) add(i, $urandom_range(1, 7));
            m_urgent = ($urandom_range(3) == 0);
            step($urandom_range(3) != 0);
        end
        m_urgent = 1'b0;
        drain("random", 200);
        for (int i = 0; i < NM; i++) chk("acks_conserved", seen[i], issued[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
